// File: rtl/ntt_ctrl_pkg.sv
// Shared types for the MDC NTT pipeline controller: FSM state encoding and
// the coefficient-pair address width helper.
package ntt_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    STORE,
    DONE
  } state_e;

  // One address selects a coefficient pair, so N/2 entries need LOGN-1 bits.
  function automatic int pair_aw(input int logn);
    return logn - 1;
  endfunction

endpackage

// File: rtl/shiftreg.sv
// Fixed-depth delay line with synchronous active-low clear; DEPTH=0 is a wire.
module shiftreg #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  if (DEPTH == 0) begin : g_pass
    assign dout_o = din_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= din_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/ntt_mdc_ctrl.sv
// Job sequencer for the MDC NTT pipeline: load N/2 pairs, wait out the pipeline
// latency, store N/2 pairs, pulse done. Optional cycle counter: NTT_CTRL_PERF_CNT_EN.
module ntt_mdc_ctrl
  import ntt_ctrl_pkg::*;
#(
  parameter int LOGN       = 10,
  parameter int LAT_FNTT   = 40,
  parameter int LAT_INTT   = 50,
  parameter int DELAY_BRAM = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic                      req_intt,
  output logic                      rdy,
  output logic                      busy,
  output logic                      done,
  output logic                      intt,
  output logic                      src_rd_en,
  output logic [pair_aw(LOGN)-1:0]  src_addr,
  output logic                      stage_start,
  output logic                      dst_wr_en,
  output logic [pair_aw(LOGN)-1:0]  dst_addr,
  output logic [31:0]               cyc_cnt
);

  localparam int AW    = pair_aw(LOGN);
  localparam int HALF  = 1 << AW;
  localparam int W_F   = DELAY_BRAM + LAT_FNTT - HALF;
  localparam int W_I   = DELAY_BRAM + LAT_INTT - HALF;
  localparam int W_MAX = (W_F > W_I) ? W_F : W_I;
  localparam int WCW   = (W_MAX > 1) ? $clog2(W_MAX) : 1;

  localparam logic [AW-1:0]  ADDR_LAST = AW'(HALF - 1);
  localparam logic [WCW-1:0] WL_F      = WCW'((W_F > 0) ? W_F - 1 : 0);
  localparam logic [WCW-1:0] WL_I      = WCW'((W_I > 0) ? W_I - 1 : 0);

  if (LOGN < 2) begin : g_bad_logn
    $error("ntt_mdc_ctrl: LOGN must be at least 2");
  end
  if ((DELAY_BRAM + LAT_FNTT < HALF) || (DELAY_BRAM + LAT_INTT < HALF)) begin : g_bad_lat
    $error("ntt_mdc_ctrl: DELAY_BRAM + pipeline latency must cover N/2 load cycles");
  end

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           intt_q, intt_d;
  logic           ss_raw;
  logic           wait_skip;
  logic [WCW-1:0] wait_last;

  assign wait_skip = intt_q ? (W_I == 0) : (W_F == 0);
  assign wait_last = intt_q ? WL_I : WL_F;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wcnt_q  <= '0;
      intt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      intt_q  <= intt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    intt_d  = intt_q;
    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        wcnt_d = '0;
        if (req) begin
          intt_d  = req_intt;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (addr_q == ADDR_LAST) begin
          addr_d  = '0;
          wcnt_d  = '0;
          state_d = wait_skip ? STORE : WAIT;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      WAIT: begin
        if (wcnt_q == wait_last) begin
          wcnt_d  = '0;
          addr_d  = '0;
          state_d = STORE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      STORE: begin
        if (addr_q == ADDR_LAST) begin
          addr_d  = '0;
          state_d = DONE;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low combinationally while rst is held, not just after the edge.
  assign rdy       = rst && (state_q == IDLE);
  assign busy      = rst && (state_q != IDLE);
  assign done      = rst && (state_q == DONE);
  assign intt      = rst && intt_q;
  assign src_rd_en = rst && (state_q == LOAD);
  assign src_addr  = src_rd_en ? addr_q : '0;
  assign dst_wr_en = rst && (state_q == STORE);
  assign dst_addr  = dst_wr_en ? addr_q : '0;

  shiftreg #(
    .DEPTH (DELAY_BRAM),
    .WIDTH (1)
  ) u_ss_dly (
    .clk    (clk),
    .rst    (rst),
    .din_i  (src_rd_en),
    .dout_o (ss_raw)
  );

  assign stage_start = rst && ss_raw;

`ifdef NTT_CTRL_PERF_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_q <= '0;
    end else if (rdy && req) begin
      cyc_q <= '0;
    end else if (state_q != IDLE) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cyc_cnt = rst ? cyc_q : 32'd0;
`else
  assign cyc_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ntt_mdc_ctrl.sv
// Self-checking bench for ntt_mdc_ctrl: directed timing scenarios plus a
// randomized run, all compared against a cycle-window reference model.
`timescale 1ns/1ps
module tb_ntt_mdc_ctrl;

  localparam int LOGN  = 4;
  localparam int LAT_F = 12;
  localparam int LAT_I = 14;
  localparam int DB    = 1;
  localparam int H     = 8;
  localparam int AW    = 3;
  localparam int LAT_FZ = 7;
`ifdef NTT_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req = 1'b0;
  logic req_intt = 1'b0;
  logic req_z = 1'b0;
  logic req_intt_z = 1'b0;

  always #5 clk = ~clk;

  logic          rdy, busy, done, intt, src_rd_en, stage_start, dst_wr_en;
  logic [AW-1:0] src_addr, dst_addr;
  logic [31:0]   cyc_cnt;

  logic          rdy_z, busy_z, done_z, intt_z, src_rd_en_z, stage_start_z, dst_wr_en_z;
  logic [AW-1:0] src_addr_z, dst_addr_z;
  logic [31:0]   cyc_cnt_z;

  ntt_mdc_ctrl #(.LOGN(LOGN), .LAT_FNTT(LAT_F), .LAT_INTT(LAT_I), .DELAY_BRAM(DB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_intt(req_intt),
    .rdy(rdy), .busy(busy), .done(done), .intt(intt),
    .src_rd_en(src_rd_en), .src_addr(src_addr), .stage_start(stage_start),
    .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .cyc_cnt(cyc_cnt)
  );

  ntt_mdc_ctrl #(.LOGN(LOGN), .LAT_FNTT(LAT_FZ), .LAT_INTT(LAT_I), .DELAY_BRAM(DB)) dut_z (
    .clk(clk), .rst(rst), .req(req_z), .req_intt(req_intt_z),
    .rdy(rdy_z), .busy(busy_z), .done(done_z), .intt(intt_z),
    .src_rd_en(src_rd_en_z), .src_addr(src_addr_z), .stage_start(stage_start_z),
    .dst_wr_en(dst_wr_en_z), .dst_addr(dst_addr_z), .cyc_cnt(cyc_cnt_z)
  );

  wire [44:0] obs = {rdy, busy, done, intt, src_rd_en, src_addr, stage_start,
                     dst_wr_en, dst_addr, cyc_cnt};

  int errors = 0;
  int checks = 0;

  // Reference model: a job is a start cycle plus a mode; every output is a window on it.
  int cyc = 0;
  bit has_job = 1'b0;
  int js = 0;
  bit jm = 1'b0;
  int perf = 0;

  function automatic int job_len(input bit m);
    return H + DB + (m ? LAT_I : LAT_F) + 1;
  endfunction

  function automatic bit m_busy();
    return has_job && ((cyc - js) < job_len(jm));
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      has_job <= 1'b0;
      jm      <= 1'b0;
      perf    <= 0;
    end else if (req && !m_busy()) begin
      has_job <= 1'b1;
      js      <= cyc + 1;
      jm      <= req_intt;
      perf    <= 0;
    end else if (m_busy()) begin
      perf <= perf + 1;
    end
  end

  function automatic logic [44:0] exp_vec();
    int r, lat;
    bit b, s, ss, d, dn;
    logic [AW-1:0] sa, da;
    logic [31:0] pc;
    if (!rst) return '0;
    lat = jm ? LAT_I : LAT_F;
    r   = cyc - js;
    b   = m_busy();
    s   = b && (r < H);
    ss  = b && (r >= DB) && (r < DB + H);
    d   = b && (r >= DB + lat) && (r < DB + lat + H);
    dn  = b && (r == H + DB + lat);
    sa  = s ? AW'(r) : '0;
    da  = d ? AW'(r - DB - lat) : '0;
    pc  = PERF ? 32'(perf) : 32'd0;
    return {!b, b, dn, jm, s, sa, ss, d, da, pc};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (obs !== 45'd0) begin
        errors++;
        $display("FAIL reset_outputs obs=%h required=0", obs);
      end
    end
    checks++;
    if (rdy_z !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy_z obs=%b required=0", rdy_z);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release_rdy rdy=%b busy=%b required rdy=1 busy=0", rdy, busy);
    end
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL release_trace obs=%h required=%h", obs, exp_vec());
    end
  endtask

  task automatic test_single_job(input bit m, input int want_dst, input int want_done,
                                 input int want_cnt);
    int k;
    int first_dst = -1;
    int first_src = -1;
    int first_ss  = -1;
    int done_at   = -1;
    int n_dst     = 0;
    req      = 1'b1;
    req_intt = m;
    k        = cyc;
    @(negedge clk);
    req      = 1'b0;
    req_intt = 1'($urandom_range(0, 1));
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL job%0d_trace cyc=+%0d obs=%h required=%h", m, cyc - k, obs, exp_vec());
      end
      if (src_rd_en && first_src < 0) first_src = cyc - k;
      if (stage_start && first_ss < 0) first_ss = cyc - k;
      if (dst_wr_en && first_dst < 0) first_dst = cyc - k;
      if (dst_wr_en) n_dst++;
      if (done && done_at < 0) done_at = cyc - k;
      @(negedge clk);
    end
    $display("job mode=%0d src=+%0d stage_start=+%0d dst=+%0d done=+%0d cyc_cnt=%0d",
             m, first_src, first_ss, first_dst, done_at, cyc_cnt);
    checks++;
    if (first_src !== 1 || first_ss !== 1 + DB) begin
      errors++;
      $display("FAIL job%0d_load_start src=+%0d ss=+%0d required src=+1 ss=+%0d",
               m, first_src, first_ss, 1 + DB);
    end
    checks++;
    if (first_dst !== want_dst) begin
      errors++;
      $display("FAIL job%0d_first_dst got=+%0d required=+%0d", m, first_dst, want_dst);
    end
    checks++;
    if (done_at !== want_done) begin
      errors++;
      $display("FAIL job%0d_done got=+%0d required=+%0d", m, done_at, want_done);
    end
    checks++;
    if (n_dst !== H) begin
      errors++;
      $display("FAIL job%0d_dst_count got=%0d required=%0d", m, n_dst, H);
    end
    checks++;
    if (intt !== m || cyc_cnt !== (PERF ? 32'(want_cnt) : 32'd0)) begin
      errors++;
      $display("FAIL job%0d_hold intt=%b cyc_cnt=%0d required intt=%b cyc_cnt=%0d",
               m, intt, cyc_cnt, m, PERF ? want_cnt : 0);
    end
  endtask

  task automatic test_back_to_back();
    int starts[$];
    int k;
    req      = 1'b1;
    req_intt = 1'b0;
    k        = cyc;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_trace cyc=+%0d obs=%h required=%h", cyc - k, obs, exp_vec());
      end
      if (src_rd_en && src_addr == '0) starts.push_back(cyc - k);
    end
    req = 1'b0;
    $display("job back_to_back loads_started=%0d", starts.size());
    checks++;
    if (starts.size() < 2) begin
      errors++;
      $display("FAIL b2b_count got=%0d required>=2", starts.size());
    end else if (starts[1] - starts[0] !== 23) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d required=23", starts[1] - starts[0]);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_drain obs=%h required=%h", obs, exp_vec());
      end
    end
  endtask

  task automatic test_reset_midjob();
    int k;
    int n_done = 0;
    int n_ss   = 0;
    req      = 1'b1;
    req_intt = 1'($urandom_range(0, 1));
    k        = cyc;
    @(negedge clk);
    req = 1'b0;
    while (cyc < k + 5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 45'd0) begin
      errors++;
      $display("FAIL midjob_reset obs=%h required=0", obs);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1 || busy !== 1'b0 || intt !== 1'b0 || src_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL midjob_release rdy=%b busy=%b intt=%b src=%b required 1 0 0 0",
               rdy, busy, intt, src_rd_en);
    end
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL midjob_trace obs=%h required=%h", obs, exp_vec());
      end
      if (done) n_done++;
      if (stage_start) n_ss++;
      @(negedge clk);
    end
    $display("job aborted_by_reset done_pulses=%0d stage_start_after=%0d", n_done, n_ss);
    checks++;
    if (n_done !== 0 || n_ss !== 0) begin
      errors++;
      $display("FAIL midjob_leak done=%0d stage_start=%0d required 0 0", n_done, n_ss);
    end
  endtask

  task automatic test_random();
    int jobs = 0;
    for (int i = 0; i < 800; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random_trace step=%0d obs=%h required=%h", i, obs, exp_vec());
      end
      if (rst && req && rdy) begin
        jobs++;
        $display("job random#%0d mode=%0d at cyc=%0d", jobs, req_intt, cyc);
      end
      rst      = ($urandom_range(0, 149) != 0);
      req      = ($urandom_range(0, 3) == 0);
      req_intt = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    rst = 1'b1;
    req = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL random_settle obs=%h required=%h", obs, exp_vec());
    end
  endtask

  task automatic test_wait_skip();
    int k;
    int first_dst = -1;
    int last_dst  = -1;
    int done_at   = -1;
    int n_busy    = 0;
    req_z      = 1'b1;
    req_intt_z = 1'b0;
    k          = cyc;
    @(negedge clk);
    req_z = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (dst_wr_en_z && first_dst < 0) first_dst = cyc - k;
      if (dst_wr_en_z) last_dst = cyc - k;
      if (done_z && done_at < 0) done_at = cyc - k;
      if (busy_z) n_busy++;
      @(negedge clk);
    end
    $display("job wait_skip dst=+%0d..+%0d done=+%0d busy_cycles=%0d",
             first_dst, last_dst, done_at, n_busy);
    checks++;
    if (first_dst !== 9 || last_dst !== 16) begin
      errors++;
      $display("FAIL skip_dst_window got=+%0d..+%0d required=+9..+16", first_dst, last_dst);
    end
    checks++;
    if (done_at !== 17) begin
      errors++;
      $display("FAIL skip_done got=+%0d required=+17", done_at);
    end
    checks++;
    if (n_busy !== 17 || rdy_z !== 1'b1) begin
      errors++;
      $display("FAIL skip_busy got=%0d rdy=%b required=17 rdy=1", n_busy, rdy_z);
    end
  endtask

  initial begin
    test_reset();
    test_single_job(1'b0, DB + LAT_F + 1, H + DB + LAT_F + 1, H + DB + LAT_F + 1);
    test_single_job(1'b1, DB + LAT_I + 1, H + DB + LAT_I + 1, H + DB + LAT_I + 1);
    test_back_to_back();
    test_reset_midjob();
    test_random();
    test_wait_skip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
